// File: rtl/h264_stream_mem.sv
// h264_stream_mem: preloadable bitstream word store with pipelined fetch, plus a capture buffer for packer words.
// Latency: a fetch accept gives data_valid RD_LAT cycles later; capture readback is registered (1 cycle).
// Backpressure: fetch_ready gates accepts and is throttled by an LFSR when STREAM_MEM_STALL_EN is defined; no output backpressure.
module h264_stream_mem #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32768,
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 2,      // legal range 1..8
    parameter int CAP_DEPTH = 4096,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(CAP_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_word,
    output logic              addr_err,
    input  logic              cap_we,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [CW-2:0]     cap_rd_addr,
    output logic [DATA_W-1:0] cap_rd_data,
    output logic [CW-1:0]     cap_count,
    output logic              cap_ovf
);

    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [CW-1:0]     CAP_FULL = CW'(CAP_DEPTH);

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] cap_mem [CAP_DEPTH];

    // One flag per pipeline stage; the last stage drives the outputs.
    logic              vld_q [RD_LAT];
    logic [DATA_W-1:0] dat_q [RD_LAT];

    logic ready_q;
    logic accept;
    logic in_range;
    logic cap_wr;

    assign in_range = (fetch_addr < DEPTH_A);
    assign accept   = fetch_req & fetch_ready;
    assign cap_wr   = cap_we & (cap_count < CAP_FULL);

    assign data_valid = vld_q[RD_LAT-1];
    assign data_word  = dat_q[RD_LAT-1];

`ifdef STREAM_MEM_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped every cycle to throttle accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Stall when both low LFSR bits are set (about one cycle in four).
    assign fetch_ready = ready_q & (~lfsr[0] | ~lfsr[1]);
`else
    assign fetch_ready = ready_q;
`endif

    // ready_q holds fetch_ready low during reset and releases it on the first edge after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Bitstream store write port; the fetch read happens on the same edge, so a collision returns old data.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // Read pipeline: stage 0 reads the store (zero for out-of-range), later stages delay; data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            if (accept) begin
                dat_q[0] <= in_range ? mem[fetch_addr[AW-1:0]] : '0;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    // Sticky out-of-range flag, set on the accept edge of a bad address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (accept && !in_range) begin
            addr_err <= 1'b1;
        end
    end

    // Capture buffer storage, appended at the current count.
    always_ff @(posedge clk) begin
        if (cap_wr) begin
            cap_mem[cap_count[CW-2:0]] <= cap_data;
        end
    end

    // Saturating capture count and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_count <= '0;
            cap_ovf   <= 1'b0;
        end else if (cap_wr) begin
            cap_count <= cap_count + CW'(1);
        end else if (cap_we) begin
            cap_ovf   <= 1'b1;
        end
    end

    // Registered capture readback; same-edge write to the same index returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_rd_data <= '0;
        end else begin
            cap_rd_data <= cap_mem[cap_rd_addr];
        end
    end

endmodule
